// File: rtl/vec_normalize_if.sv
// Operand/result handshake bundle for vec_normalize.
// A transfer happens on a rising edge where valid & ready are both high. The
// sender holds its data stable while valid is high, and ready never depends
// combinationally on valid.
interface vec_normalize_if;
  logic        in_valid;
  logic        in_ready;
  logic [19:0] x;
  logic [19:0] y;
  logic [19:0] z;
  logic [10:0] mold;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] nx;
  logic [11:0] ny;
  logic [11:0] nz;
  logic [2:0]  sat;
  logic        div_zero;

  modport slave (
    input  in_valid, x, y, z, mold, out_ready,
    output in_ready, out_valid, nx, ny, nz, sat, div_zero
  );

  modport master (
    output in_valid, x, y, z, mold, out_ready,
    input  in_ready, out_valid, nx, ny, nz, sat, div_zero
  );
endinterface

// File: rtl/vec_normalize.sv
// Divides a signed 20-bit vector by its magnitude, giving Q1.10 unit components.
// Three restoring dividers share one FSM and an 11-step bit counter.
module vec_normalize (
  input  logic            clk,
  input  logic            rst_n,
  vec_normalize_if.slave  bus,
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [3:0]        cnt;
  logic [10:0]       mold_r;
  logic [2:0]        neg_r;
  logic [2:0]        sat_r;
  logic              dz_r;
  logic [2:0][20:0]  rem;
  logic [2:0][10:0]  quo;

  logic [11:0]       nx_r, ny_r, nz_r;
  logic [2:0]        sat_o;
  logic              dz_o;

  logic              accept;
  logic [2:0][19:0]  comp_in;
  logic [2:0][19:0]  a_in;
  logic [2:0]        s_in;
  logic [2:0]        qbit;
  logic [2:0][20:0]  rem_sub;
  logic [2:0][10:0]  q_final;
  logic [2:0][10:0]  q_sel;
  logic [2:0][11:0]  res;

  assign accept = bus.in_valid & bus.in_ready;

  always_comb begin
    comp_in = {bus.z, bus.y, bus.x};
    a_in    = '0;
    s_in    = '0;
    qbit    = '0;
    rem_sub = '0;
    q_final = '0;
    q_sel   = '0;
    res     = '0;
    for (int i = 0; i < 3; i++) begin
      a_in[i] = comp_in[i][19] ? 20'(-comp_in[i]) : comp_in[i];
      // Saturation compares at 21 bits so 2*mold cannot overflow.
      s_in[i] = {1'b0, a_in[i]} >= {9'b0, bus.mold, 1'b0};
      qbit[i] = rem[i] >= {10'b0, mold_r};
      rem_sub[i] = qbit[i] ? (rem[i] - {10'b0, mold_r}) : rem[i];
      q_final[i] = {quo[i][9:0], qbit[i]};
      if (dz_r)
        q_sel[i] = 11'd0;
      else if (sat_r[i])
        q_sel[i] = 11'h7FF;
      else
        q_sel[i] = q_final[i];
      res[i] = neg_r[i] ? 12'(-{1'b0, q_sel[i]}) : {1'b0, q_sel[i]};
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = DIV;
      DIV:     if (cnt == 4'd0) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      mold_r <= '0;
      neg_r  <= '0;
      sat_r  <= '0;
      dz_r   <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      nx_r   <= '0;
      ny_r   <= '0;
      nz_r   <= '0;
      sat_o  <= '0;
      dz_o   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        mold_r <= bus.mold;
        neg_r  <= {bus.z[19], bus.y[19], bus.x[19]};
        sat_r  <= s_in;
        dz_r   <= (bus.mold == 11'd0);
        for (int i = 0; i < 3; i++) rem[i] <= {1'b0, a_in[i]};
        quo    <= '0;
        cnt    <= 4'd10;
      end else if (state == DIV) begin
        for (int i = 0; i < 3; i++) begin
          rem[i] <= {rem_sub[i][19:0], 1'b0};
          quo[i] <= q_final[i];
        end
        cnt <= cnt - 4'd1;
        // Last step: publish the results together with the final quotient bit.
        if (cnt == 4'd0) begin
          nx_r  <= res[0];
          ny_r  <= res[1];
          nz_r  <= res[2];
          sat_o <= dz_r ? 3'b000 : sat_r;
          dz_o  <= dz_r;
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.nx        = nx_r;
  assign bus.ny        = ny_r;
  assign bus.nz        = nz_r;
  assign bus.sat       = sat_o;
  assign bus.div_zero  = dz_o;
  assign state_dbg     = state;

endmodule

// File: doc/vec_normalize.md
# vec_normalize

Iterative fixed-point vector normalizer placed directly downstream of the vector-magnitude stage. It accepts a signed 20-bit vector (x, y, z) together with its 11-bit magnitude. It returns each component divided by the magnitude as a signed Q1.10 value, giving the unit direction vectors consumed by the ray-setup logic. Division uses three parallel restoring dividers that share one FSM and bit counter. Input and output use valid/ready handshakes.

## Interface
- Parameters: none; all widths are fixed as listed below.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- in_valid  in  1  the operand set on x, y, z and mold is valid.
- in_ready  out  1  the block can accept operands; high only in IDLE.
- x, y, z  in  20  signed two's-complement vector components.
- mold  in  11  unsigned magnitude of (x, y, z). The caller aligns it with x, y, z, which arrive 2 cycles earlier than mold from the magnitude stage.
- out_valid  out  1  the normalized result is valid.
- out_ready  in  1  the consumer accepts the result.
- nx, ny, nz  out  12  signed Q1.10 normalized components.
- sat  out  3  per-component saturation flag; bit 0 = x, bit 1 = y, bit 2 = z.
- div_zero  out  1  mold was 0.

## Operation
- FSM has three states:
  - IDLE: in_ready = 1. The state moves to DIV on an in_valid & in_ready edge.
  - DIV: the state moves to DONE after 11 iteration edges.
  - DONE: out_valid = 1. The state moves to IDLE on an out_valid & out_ready edge.
- On the accept edge, the block registers the following:
  - the sign of each component (bit 19);
  - the magnitude a = |c| as a 20-bit unsigned value (|-2^19| = 2^19 fits);
  - mold;
  - the saturation flag s = (a >= 2*mold), compared at 21 bits;
  - div_zero = (mold == 0);
  - the remainder rem = a (21 bits);
  - the bit counter set to 10.
- Each DIV edge (restoring step, per component):
  - If rem >= mold, the quotient bit is 1 and rem becomes rem − mold.
  - Otherwise the quotient bit is 0.
  - rem is then shifted left by 1.
  - The quotient shifts in MSB first (bits 10 down to 0), and the counter decrements.
- Because a < 2*mold whenever s = 0, the remainder stays below 2*mold. The 11-bit quotient q therefore equals floor(a*1024/mold), truncated toward zero, with q ≤ 2047.
- Result per component:
  - If div_zero, the result is 0 and sat = 0.
  - Else if s, q is forced to 2047.
  - The output is −q when the sign is negative, else q. Range is −2047..2047; −2048 is never produced.
- All three components always run the full 11 steps, including the saturated and divide-by-zero cases. Latency is therefore fixed.
- nx, ny, nz, sat and div_zero are registered. They change only on the DIV→DONE edge and hold stable while out_valid = 1 and out_ready = 0.
- in_valid is ignored outside IDLE. Operands are sampled only on the accept edge; changes to x, y, z or mold after that edge do not affect the result.

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - state IDLE, in_ready = 1, out_valid = 0;
  - nx, ny, nz = 0, sat = 0, div_zero = 0;
  - counter and remainders = 0.
- Reset during DIV or DONE aborts the operation immediately. No result is delivered, and the first clean accept after reset release behaves normally.
- Latency: operands accepted on edge E0 give out_valid = 1 after edge E11.
- Backpressure: if out_ready is already high in DONE, the result is consumed on edge E12 and in_ready is high again after E12. The next accept can occur at E13, so maximum throughput is one vector per 13 cycles.
- in_ready and out_valid are never high in the same cycle.

## Test plan
- Basic: x=3, y=0, z=4, mold=5 accepted at E0, out_ready=1 → after E11: out_valid=1, nx=614, ny=0, nz=819, sat=0, div_zero=0; in_ready=1 after E12.
- Signs: x=−3, y=−4, z=0, mold=5 → nx=12'hD9A (−614), ny=12'hCCD (−819), nz=0. Exact case x=7, mold=7 → nx=1024.
- Saturation: x=100, y=−100, z=19, mold=10 → nx=2047, ny=12'h801 (−2047), nz=1945, sat=3'b011.
- Divide by zero: mold=0, x=5, y=−5, z=0 → nx=ny=nz=0, div_zero=1, sat=0, still asserted after E11.
- Backpressure and ignored input: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with new operands → outputs and flags stay constant, in_ready stays 0, and the new operands are not accepted. Raise out_ready → one transfer, then IDLE.
- Reset mid-operation: drop rst_n at E5 during DIV → out_valid=0 and in_ready=1 immediately, outputs 0. After release, x=3, y=0, z=4, mold=5 again → nx=614, nz=819 with the full 11-cycle latency.
